// File: rtl/bp_me_pkg.sv
// Shared definitions for the mem NoC to DRAM bridge: header layout, opcodes, FSM states.
package bp_me_pkg;

  localparam int hdr_len_lsb_lp  = 8;
  localparam int hdr_op_lsb_lp   = 12;
  localparam int hdr_size_lsb_lp = 14;
  localparam int hdr_addr_lsb_lp = 18;
  localparam int hdr_src_lsb_lp  = 56;
  localparam int addr_width_lp   = 38;

  typedef enum logic [1:0] {
    e_op_rd = 2'b00,
    e_op_wr = 2'b01
  } bp_me_op_e;

  typedef enum logic [2:0] {
    e_hdr, e_wr, e_wr_ack, e_rd_hdr, e_rd, e_drop
  } bp_me_state_e;

  typedef struct packed {
    logic [7:0]               src;
    logic [addr_width_lp-1:0] addr;
    logic [3:0]               size;
    logic [1:0]               op;
    logic [3:0]               len;
    logic [7:0]               dest;
  } bp_me_hdr_s;

  // Response headers only carry routing, length and opcode; everything else is zero.
  function automatic bp_me_hdr_s resp_hdr(logic [7:0] dest, logic [3:0] len, bp_me_op_e op);
    bp_me_hdr_s h;
    h      = '0;
    h.dest = dest;
    h.len  = len;
    h.op   = op;
    return h;
  endfunction

endpackage

// File: rtl/bp_mem_noc_dram_bridge_if.sv
// Valid/ready data channel; master drives v/data, slave drives ready.
interface bp_mem_noc_dram_bridge_if #(parameter int width_p = 64);
  logic               v;
  logic [width_p-1:0] data;
  logic               ready;

  modport master (output v, data, input ready);
  modport slave  (input v, data, output ready);
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO buffering DRAM read data ahead of the response link.
module bsg_two_fifo #(
  parameter int width_p = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  bp_mem_noc_dram_bridge_if.slave          enq_i,
  bp_mem_noc_dram_bridge_if.master         deq_o,
  output logic [1:0]                       cnt_o
);

  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;
  logic               enq_fire, deq_fire;

  assign enq_i.ready = (cnt_q != 2'd2);
  assign deq_o.v     = (cnt_q != 2'd0);
  assign deq_o.data  = mem_q[rptr_q];
  assign cnt_o       = cnt_q;
  assign enq_fire    = enq_i.v & enq_i.ready;
  assign deq_fire    = deq_o.v & deq_o.ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq_fire) wptr_q <= ~wptr_q;
      if (deq_fire) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, enq_fire} - {1'b0, deq_fire};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[wptr_q] <= enq_i.data;
  end

endmodule

// File: rtl/bp_mem_noc_dram_bridge.sv
// Terminates mem NoC command packets into DRAM beats and returns read data / write acks.
module bp_mem_noc_dram_bridge
  import bp_me_pkg::*;
#(
  parameter int flit_width_p      = 64,
  parameter int max_outstanding_p = 2
) (
  input  logic                    clk_i,
  input  logic                    async_reset_i,
  input  logic [flit_width_p+1:0] cmd_link_i,
  output logic [flit_width_p+1:0] cmd_link_o,
  output logic                    dram_v_o,
  input  logic                    dram_ready_i,
  output logic                    dram_w_o,
  output logic [37:0]             dram_addr_o,
  output logic [flit_width_p-1:0] dram_data_o,
  input  logic                    dram_data_v_i,
  input  logic [flit_width_p-1:0] dram_data_i,
  output logic                    dram_data_yumi_o
);

  localparam logic [7:0] max_os_lp = 8'(max_outstanding_p);

  logic                    in_v, in_rdy, out_v, out_rdy;
  logic [flit_width_p-1:0] in_data, out_data;
  logic [3:0]              in_len, in_size;
  logic [1:0]              in_op;
  logic [7:0]              in_src;
  logic [37:0]             in_addr;

  assign in_v    = cmd_link_i[flit_width_p+1];
  assign in_data = cmd_link_i[flit_width_p:1];
  assign out_rdy = cmd_link_i[0];
  // Readiness is forced low while reset is held since e_hdr would otherwise raise it.
  assign cmd_link_o = {out_v, out_data, in_rdy & ~async_reset_i};

  assign in_len  = in_data[hdr_len_lsb_lp  +: 4];
  assign in_op   = in_data[hdr_op_lsb_lp   +: 2];
  assign in_size = in_data[hdr_size_lsb_lp +: 4];
  assign in_addr = in_data[hdr_addr_lsb_lp +: addr_width_lp];
  assign in_src  = in_data[hdr_src_lsb_lp  +: 8];

  bp_me_state_e state_q, state_d;
  logic [37:0]  base_q, base_d;
  logic [3:0]   size_q, size_d, len_q, len_d;
  logic [7:0]   src_q, src_d, out_q, out_d;
  logic [4:0]   cnt_q, cnt_d, iss_q, iss_d, beats;
  logic [1:0]   occ;
  logic         issue;
  bp_me_hdr_s   resp;

  bp_mem_noc_dram_bridge_if #(.width_p(flit_width_p)) enq_if ();
  bp_mem_noc_dram_bridge_if #(.width_p(flit_width_p)) deq_if ();

  assign enq_if.v         = dram_data_v_i & (state_q == e_rd);
  assign enq_if.data      = dram_data_i;
  assign dram_data_yumi_o = enq_if.v & enq_if.ready;
  assign dram_data_o      = in_data;
  assign beats            = {1'b0, size_q} + 5'd1;

  bsg_two_fifo #(.width_p(flit_width_p)) rd_fifo (
    .clk_i   (clk_i),
    .reset_i (async_reset_i),
    .enq_i   (enq_if),
    .deq_o   (deq_if),
    .cnt_o   (occ)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    len_d        = len_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    iss_d        = iss_q;
    in_rdy       = 1'b0;
    out_v        = 1'b0;
    out_data     = '0;
    dram_v_o     = 1'b0;
    dram_w_o     = 1'b0;
    dram_addr_o  = base_q + {30'b0, cnt_q, 3'b0};
    deq_if.ready = 1'b0;
    issue        = 1'b0;
    resp         = '0;
    case (state_q)
      e_hdr: begin
        in_rdy = 1'b1;
        if (in_v) begin
          base_d = in_addr;
          size_d = in_size;
          len_d  = in_len;
          src_d  = in_src;
          cnt_d  = '0;
          iss_d  = '0;
          if (in_op[1])              state_d = (in_len != 4'd0) ? e_drop : e_hdr;
          else if (in_op == e_op_rd) state_d = e_rd_hdr;
          else                       state_d = (in_len != 4'd0) ? e_wr : e_wr_ack;
        end
      end
      e_wr: begin
        dram_v_o = in_v;
        in_rdy   = dram_ready_i;
        dram_w_o = 1'b1;
        if (in_v && dram_ready_i) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == {1'b0, len_q}) state_d = e_wr_ack;
        end
      end
      e_wr_ack: begin
        resp          = resp_hdr(src_q, 4'd0, e_op_wr);
        out_v         = 1'b1;
        out_data[63:0] = resp;
        if (out_rdy) state_d = e_hdr;
      end
      e_rd_hdr: begin
        resp          = resp_hdr(src_q, size_q + 4'd1, e_op_rd);
        out_v         = 1'b1;
        out_data[63:0] = resp;
        if (out_rdy) state_d = e_rd;
      end
      e_rd: begin
        // Credit covers both beats in flight at DRAM and beats parked in the FIFO.
        dram_v_o     = (iss_q < beats) && ((out_q + {6'b0, occ}) < max_os_lp);
        dram_addr_o  = base_q + {30'b0, iss_q, 3'b0};
        issue        = dram_v_o & dram_ready_i;
        if (issue) iss_d = iss_q + 5'd1;
        out_v        = deq_if.v;
        out_data     = deq_if.data;
        deq_if.ready = out_rdy;
        if (deq_if.v && out_rdy) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == beats) state_d = e_hdr;
        end
      end
      e_drop: begin
        in_rdy = 1'b1;
        if (in_v) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == {1'b0, len_q}) state_d = e_hdr;
        end
      end
      default: state_d = e_hdr;
    endcase
    out_d = out_q + {7'b0, issue} - {7'b0, dram_data_yumi_o};
  end

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q <= e_hdr;
      base_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      len_q   <= len_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      out_q   <= out_d;
    end
  end

endmodule
